// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-unit bundle between the pipeline datapath (master) and the control unit (slave)
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs, id_rt, ex_writeReg;
  logic ex_RegWrite, ex_MemToReg, mem_zero, mem_BranchEq, mem_Jump, mem_MemToReg, mem_MemWrite, dmem_ready;
  logic pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
  logic mem_wb_bubble, dmem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs, id_rt, ex_writeReg, ex_RegWrite, ex_MemToReg, mem_zero, mem_BranchEq, mem_Jump,
           mem_MemToReg, mem_MemWrite, dmem_ready,
    input  pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_bubble, dmem_req, mem_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_writeReg, ex_RegWrite, ex_MemToReg, mem_zero, mem_BranchEq, mem_Jump,
           mem_MemToReg, mem_MemWrite, dmem_ready,
    output pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_bubble, dmem_req, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush control with load-use, MEM redirect and dmem wait/timeout handling
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic clr,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic mem_acc, taken, lu, hold, go, redirect, lu_bubble;
  always_comb begin
    mem_acc   = bus.mem_MemToReg | bus.mem_MemWrite;
    taken     = (bus.mem_BranchEq & bus.mem_zero) | bus.mem_Jump;
    lu        = bus.ex_MemToReg & bus.ex_RegWrite & (bus.ex_writeReg != 5'd0) &
                ((bus.ex_writeReg == bus.id_rs) | (bus.ex_writeReg == bus.id_rt));
    hold      = ~bus.dmem_ready & ((state_q == MEM_WAIT) | ((state_q == RUN) & mem_acc));
    go        = ~hold & (state_q != ERR);
    redirect  = go & taken;
    lu_bubble = go & ~taken & lu;
  end
  assign bus.pc_en         = go & ~lu_bubble;
  assign bus.pc_sel_branch = redirect;
  assign bus.if_id_en      = go & ~lu_bubble;
  assign bus.if_id_flush   = redirect;
  assign bus.id_ex_en      = go;
  assign bus.id_ex_flush   = redirect | lu_bubble;
  assign bus.ex_mem_en     = go;
  assign bus.ex_mem_flush  = redirect;
  assign bus.mem_wb_bubble = ~go;
  assign bus.dmem_req      = (state_q == MEM_WAIT) | ((state_q == RUN) & mem_acc);
  assign bus.mem_err       = state_q == ERR;
  assign bus.stall_cnt     = stall_q;
  assign bus.flush_cnt     = flush_q;
  // wait_q is zero in RUN, so the first stalled cycle naturally lands on a count of one
  always_comb begin
    wait_inc = wait_q + WW'(1);
    state_d  = hold ? ((wait_inc >= WW'(WAIT_MAX)) ? ERR : MEM_WAIT) : ((state_q == MEM_WAIT) ? RUN : state_q);
    wait_d   = hold ? wait_inc : ((state_q == MEM_WAIT) ? '0 : wait_q);
    stall_d  = (~bus.pc_en & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d  = (redirect & ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus checked every cycle against a wait-count/error-flag model of the hazard rules
module tb_pipe_hazard_ctrl;
  localparam int WM  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (.clk(clk), .clr(clr), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  int m_waited = 0, n_waited = 0, m_stall = 0, n_stall = 0, m_flush = 0, n_flush = 0;
  bit m_inwait = 0, n_inwait = 0, m_err = 0, n_err = 0;
  always @(posedge clk or negedge clr)
    if (!clr) begin
      m_waited = 0; m_inwait = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_waited = n_waited; m_inwait = n_inwait; m_err = n_err; m_stall = n_stall; m_flush = n_flush;
    end
  // vector order: pc_en sel if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en ex_mem_flush bubble req err
  always @(negedge clk) begin
    bit acc, tk, lu, frz, rd, lb;
    logic [10:0] e;
    acc = bus.mem_MemToReg || bus.mem_MemWrite;
    tk  = (bus.mem_BranchEq && bus.mem_zero) || bus.mem_Jump;
    lu  = bus.ex_MemToReg && bus.ex_RegWrite && bus.ex_writeReg != 0 &&
          (bus.ex_writeReg == bus.id_rs || bus.ex_writeReg == bus.id_rt);
    frz = !m_err && !bus.dmem_ready && (m_inwait || acc);
    rd  = !m_err && !frz && tk;
    lb  = !m_err && !frz && !tk && lu;
    if (m_err) e = 11'b00000000101;
    else if (frz) e = 11'b00000000110;
    else e = {!lb, rd, !lb, rd, 1'b1, rd | lb, 1'b1, rd, 1'b0, acc | m_inwait, 1'b0};
    chk("ctrl", {bus.pc_en, bus.pc_sel_branch, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
                 bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_bubble, bus.dmem_req, bus.mem_err}, e);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    chk("flush_cnt", bus.flush_cnt, m_flush);
    n_err = m_err; n_inwait = m_inwait; n_waited = m_waited;
    if (!m_err && frz) begin
      n_waited = m_waited + 1;
      n_err    = n_waited >= WM;
      n_inwait = !n_err;
    end else if (!m_err) begin
      n_waited = 0;
      n_inwait = 0;
    end
    n_stall = (!e[10] && m_stall < SAT) ? m_stall + 1 : m_stall;
    n_flush = (rd && m_flush < SAT) ? m_flush + 1 : m_flush;
  end
  task automatic idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.ex_writeReg = 0; bus.ex_RegWrite = 0; bus.ex_MemToReg = 0;
    bus.mem_zero = 0; bus.mem_BranchEq = 0; bus.mem_Jump = 0; bus.mem_MemToReg = 0; bus.mem_MemWrite = 0;
    bus.dmem_ready = 1;
  endtask
  task automatic set_lu(input logic [4:0] w, input logic [4:0] rs, input logic [4:0] rt);
    bus.ex_MemToReg = 1; bus.ex_RegWrite = 1; bus.ex_writeReg = w; bus.id_rs = rs; bus.id_rt = rt;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
    #1;
  endtask
  initial begin
    idle();
    #1 clr = 0;
    repeat (2) tick();
    clr = 1;
    repeat (5) tick();
    mid();
    chk("reset_pc_en", bus.pc_en, 1);
    chk("reset_flushes", {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 0);
    chk("reset_cnts", {bus.stall_cnt, bus.flush_cnt}, 0);
    chk("reset_mem_err", bus.mem_err, 0);
    tick(); set_lu(8, 8, 0);
    mid();
    chk("lu_ctrl", {bus.pc_en, bus.if_id_en, bus.id_ex_flush, bus.id_ex_en}, 4'b0011);
    tick(); idle();
    mid();
    chk("lu_stall1", bus.stall_cnt, 1);
    chk("lu_resume", bus.pc_en, 1);
    tick(); set_lu(0, 0, 0);
    mid();
    chk("lu_r0_nostall", {bus.pc_en, bus.id_ex_flush}, 2'b10);
    tick(); set_lu(9, 3, 9);
    mid();
    chk("lu_rt_stall", bus.pc_en, 0);
    tick(); idle();
    mid();
    chk("lu_stall2", bus.stall_cnt, 2);
    tick(); bus.mem_BranchEq = 1; bus.mem_zero = 1;
    mid();
    chk("br_taken", {bus.pc_sel_branch, bus.pc_en, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 5'b11111);
    tick(); bus.mem_zero = 0;
    mid();
    chk("br_flush1", bus.flush_cnt, 1);
    chk("br_not_taken", {bus.pc_sel_branch, bus.if_id_flush, bus.ex_mem_flush}, 0);
    tick(); idle(); bus.mem_MemToReg = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("wait_freeze", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_bubble, bus.dmem_req}, 6'b000011);
      tick();
    end
    bus.dmem_ready = 1;
    mid();
    chk("wait_done", {bus.pc_en, bus.ex_mem_en, bus.dmem_req, bus.mem_wb_bubble}, 4'b1110);
    tick(); idle();
    mid();
    chk("wait_stall5", bus.stall_cnt, 5);
    chk("wait_back_run", {bus.dmem_req, bus.pc_en}, 2'b01);
    tick(); bus.mem_BranchEq = 1; bus.mem_zero = 1; set_lu(8, 8, 0);
    mid();
    chk("br_lu", {bus.pc_sel_branch, bus.pc_en, bus.if_id_en, bus.id_ex_flush}, 4'b1111);
    tick(); idle();
    mid();
    chk("br_lu_cnts", {bus.stall_cnt, bus.flush_cnt}, {4'd5, 4'd2});
    tick(); bus.mem_MemToReg = 1; bus.dmem_ready = 0;
    tick(); bus.mem_Jump = 1; set_lu(8, 8, 0);
    mid();
    chk("wait_br_held", {bus.pc_sel_branch, bus.pc_en, bus.if_id_flush}, 0);
    tick(); bus.dmem_ready = 1;
    mid();
    chk("wait_br_release", {bus.pc_sel_branch, bus.pc_en, bus.if_id_en, bus.id_ex_flush}, 4'b1111);
    tick(); idle();
    mid();
    chk("wait_br_cnts", {bus.stall_cnt, bus.flush_cnt}, {4'd7, 4'd3});
    tick(); bus.mem_MemToReg = 1; bus.dmem_ready = 0;
    mid();
    chk("to_first", bus.mem_err, 0);
    repeat (3) tick();
    mid();
    chk("to_fourth", {bus.mem_err, bus.dmem_req}, 2'b01);
    tick();
    mid();
    chk("to_err", {bus.mem_err, bus.dmem_req, bus.pc_en, bus.mem_wb_bubble}, 4'b1001);
    chk("to_stall11", bus.stall_cnt, 11);
    bus.dmem_ready = 1;
    repeat (10) tick();
    mid();
    chk("err_sticky", bus.mem_err, 1);
    chk("stall_sat", bus.stall_cnt, SAT);
    #1 clr = 0;
    #1;
    chk("err_clr", {bus.mem_err, bus.stall_cnt}, 0);
    tick(); clr = 1; idle();
    tick(); bus.mem_MemToReg = 1; bus.dmem_ready = 0;
    tick();
    mid();
    chk("mw_req", bus.dmem_req, 1);
    idle();
    #1;
    chk("mw_req_state", bus.dmem_req, 1);
    clr = 0;
    #1;
    chk("mw_req_reset", bus.dmem_req, 0);
    tick(); clr = 1;
    tick(); bus.mem_Jump = 1;
    repeat (16) tick();
    mid();
    chk("flush_sat", bus.flush_cnt, SAT);
    chk("jump_sel", bus.pc_sel_branch, 1);
    tick(); idle();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
